// File: rtl/ysyx_23060072_pipe_ctrl_if.sv
// Pipeline control bundle between the datapath stages and the hazard/redirect controller.
//   master : pipeline side, drives hazard/redirect requests and receives strobes
//   slave  : controller side, samples requests and drives hold/flush/redirect strobes
interface ysyx_23060072_pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             jump_flag_i;
    logic [31:0]      jump_pc_i;
    logic             clint_jump_flag_i;
    logic [31:0]      clint_jump_pc_i;
    logic             clint_hold_flag_i;
    logic             multdiv_hold_flag_i;
    logic             lsu_busy_i;
    logic             ifu_busy_i;
    logic             ex_load_flag_i;
    logic [4:0]       ex_wb_addr_i;
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_rs1_en_i;
    logic             id_rs2_en_i;

    logic             if_hold_o;
    logic             id_hold_o;
    logic             ex_hold_o;
    logic             lsu_hold_o;
    logic             id_flush_o;
    logic             ex_flush_o;
    logic             lsu_bubble_o;
    logic             pc_redirect_o;
    logic [31:0]      pc_target_o;
    logic             drop_fetch_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output jump_flag_i, jump_pc_i, clint_jump_flag_i, clint_jump_pc_i,
               clint_hold_flag_i, multdiv_hold_flag_i, lsu_busy_i, ifu_busy_i,
               ex_load_flag_i, ex_wb_addr_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_en_i, id_rs2_en_i,
        input  if_hold_o, id_hold_o, ex_hold_o, lsu_hold_o, id_flush_o, ex_flush_o,
               lsu_bubble_o, pc_redirect_o, pc_target_o, drop_fetch_o, stall_cnt_o
    );

    modport slave (
        input  jump_flag_i, jump_pc_i, clint_jump_flag_i, clint_jump_pc_i,
               clint_hold_flag_i, multdiv_hold_flag_i, lsu_busy_i, ifu_busy_i,
               ex_load_flag_i, ex_wb_addr_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_en_i, id_rs2_en_i,
        output if_hold_o, id_hold_o, ex_hold_o, lsu_hold_o, id_flush_o, ex_flush_o,
               lsu_bubble_o, pc_redirect_o, pc_target_o, drop_fetch_o, stall_cnt_o
    );
endinterface

// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Central hazard/redirect controller for the 5-stage RV32E pipeline.
// Merges LSU wait, EX redirects (branch/CLINT), EX multi-cycle holds and the ID/EX load-use
// hazard into per-stage hold/flush strobes plus one PC redirect. A redirect that arrives while
// a fetch is outstanding is parked in pend_q until the IFU can take it.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of ysyx_23060072_pipe_ctrl_if (requests in, strobes out,
//                stall_cnt_o counts cycles with if_hold_o set)
module ysyx_23060072_pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ysyx_23060072_pipe_ctrl_if.slave       bus
);
    typedef enum logic {StRun, StPend} state_e;

    state_e           state_q, state_d;
    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q;

    logic        req, exe_hold, load_use;
    logic [31:0] req_tgt;
    logic        if_hold, id_hold, ex_hold, lsu_hold, id_flush, ex_flush, bubble;
    logic        redirect, drop;
    logic [31:0] target;

    assign req      = bus.clint_jump_flag_i | bus.jump_flag_i;
    // CLINT redirect wins over a simultaneous branch
    assign req_tgt  = bus.clint_jump_flag_i ? bus.clint_jump_pc_i : bus.jump_pc_i;
    assign exe_hold = bus.clint_hold_flag_i | bus.multdiv_hold_flag_i;
    assign load_use = bus.ex_load_flag_i && (bus.ex_wb_addr_i != 5'd0) &&
                      ((bus.id_rs1_en_i && (bus.id_rs1_addr_i == bus.ex_wb_addr_i)) ||
                       (bus.id_rs2_en_i && (bus.id_rs2_addr_i == bus.ex_wb_addr_i)));

    always_comb begin
        if_hold  = 1'b0;
        id_hold  = 1'b0;
        ex_hold  = 1'b0;
        lsu_hold = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        bubble   = 1'b0;
        redirect = 1'b0;
        drop     = 1'b0;
        target   = req_tgt;
        state_d  = state_q;
        pend_d   = pend_q;
        if (!rst_n) begin
            target = RESET_PC;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.lsu_busy_i) begin
                        // EX is frozen; any redirect it raises is re-seen once LSU frees up
                        {if_hold, id_hold, ex_hold, lsu_hold} = 4'hf;
                    end else if (req) begin
                        id_flush = 1'b1;
                        ex_flush = 1'b1;
                        if (bus.ifu_busy_i) begin
                            // Outstanding fetch is wrong-path; park target until IFU is free
                            drop    = 1'b1;
                            pend_d  = req_tgt;
                            state_d = StPend;
                        end else begin
                            redirect = 1'b1;
                        end
                    end else if (exe_hold) begin
                        {if_hold, id_hold, ex_hold} = 3'h7;
                        // LSU keeps running, so the held EX-LSU entry must not retire twice
                        bubble = 1'b1;
                    end else if (load_use) begin
                        if_hold  = 1'b1;
                        ex_flush = 1'b1;
                    end
                end
                StPend: begin
                    drop   = 1'b1;
                    target = pend_q;
                    if (bus.lsu_busy_i) begin
                        {if_hold, id_hold, ex_hold, lsu_hold} = 4'hf;
                    end else begin
                        id_flush = 1'b1;
                        if (req) begin
                            ex_flush = 1'b1;
                            pend_d   = req_tgt;
                            target   = req_tgt;
                        end
                        if (!bus.ifu_busy_i) begin
                            redirect = 1'b1;
                            state_d  = StRun;
                        end else if (!req && exe_hold) begin
                            {if_hold, id_hold, ex_hold} = 3'h7;
                            bubble = 1'b1;
                        end
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            pend_q  <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (if_hold) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.if_hold_o     = if_hold;
    assign bus.id_hold_o     = id_hold;
    assign bus.ex_hold_o     = ex_hold;
    assign bus.lsu_hold_o    = lsu_hold;
    assign bus.id_flush_o    = id_flush;
    assign bus.ex_flush_o    = ex_flush;
    assign bus.lsu_bubble_o  = bubble;
    assign bus.pc_redirect_o = redirect;
    assign bus.pc_target_o   = target;
    assign bus.drop_fetch_o  = drop;
    assign bus.stall_cnt_o   = cnt_q;
endmodule

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// Scoreboard bench: the stimulus process pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the controller outputs.
module tb_ysyx_23060072_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ysyx_23060072_pipe_ctrl_if #(.CNT_W(32)) bus ();

    ysyx_23060072_pipe_ctrl #(
        .RESET_PC (32'h8000_0000),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // strobe bit order: if,id,ex,lsu hold, id_flush, ex_flush, bubble, redirect, drop
    localparam logic [8:0] IFH = 9'h100, IDH = 9'h080, EXH = 9'h040, LSH = 9'h020;
    localparam logic [8:0] IDF = 9'h010, EXF = 9'h008, BUB = 9'h004, RED = 9'h002;
    localparam logic [8:0] DRP = 9'h001, NONE = 9'h000;

    typedef struct {
        int          step;
        logic [8:0]  strobes;
        logic        chk_tgt;
        logic [31:0] tgt;
        logic        chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e = exp_q.pop_front();
            act = {bus.if_hold_o, bus.id_hold_o, bus.ex_hold_o, bus.lsu_hold_o, bus.id_flush_o,
                   bus.ex_flush_o, bus.lsu_bubble_o, bus.pc_redirect_o, bus.drop_fetch_o};
            n_checks++;
            if (act !== e.strobes) begin
                n_fail++;
                $display("FAIL strobes step %0d: got %b want %b", e.step, act, e.strobes);
            end
            if (e.chk_tgt) begin
                n_checks++;
                if (bus.pc_target_o !== e.tgt) begin
                    n_fail++;
                    $display("FAIL pc_target step %0d: got %h want %h", e.step,
                             bus.pc_target_o, e.tgt);
                end
            end
            if (e.chk_cnt) begin
                n_checks++;
                if (bus.stall_cnt_o !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_cnt step %0d: got %0d want %0d", e.step,
                             bus.stall_cnt_o, e.cnt);
                end
            end
        end
    end

    task automatic idle();
        bus.jump_flag_i         = 1'b0;
        bus.jump_pc_i           = 32'h0;
        bus.clint_jump_flag_i   = 1'b0;
        bus.clint_jump_pc_i     = 32'h0;
        bus.clint_hold_flag_i   = 1'b0;
        bus.multdiv_hold_flag_i = 1'b0;
        bus.lsu_busy_i          = 1'b0;
        bus.ifu_busy_i          = 1'b0;
        bus.ex_load_flag_i      = 1'b0;
        bus.ex_wb_addr_i        = 5'd0;
        bus.id_rs1_addr_i       = 5'd0;
        bus.id_rs2_addr_i       = 5'd0;
        bus.id_rs1_en_i         = 1'b0;
        bus.id_rs2_en_i         = 1'b0;
    endtask

    // Inputs already applied; queue expectation, then advance one clock.
    task automatic step(input logic [8:0] s, input logic ct, input logic [31:0] t,
                        input logic cc, input logic [31:0] c);
        exp_t e;
        e.step = step_no; e.strobes = s; e.chk_tgt = ct; e.tgt = t; e.chk_cnt = cc; e.cnt = c;
        exp_q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        // reset: three cycles
        for (int i = 0; i < 3; i++) step(NONE, 1'b1, 32'h8000_0000, 1'b1, 0);
        rst_n = 1'b1;
        step(NONE, 1'b0, 0, 1'b1, 0);

        // plain branch redirect
        bus.jump_flag_i = 1'b1; bus.jump_pc_i = 32'h8000_0100;
        step(IDF | EXF | RED, 1'b1, 32'h8000_0100, 1'b0, 0);
        // CLINT wins on simultaneous request
        bus.clint_jump_flag_i = 1'b1; bus.clint_jump_pc_i = 32'h8000_0200;
        step(IDF | EXF | RED, 1'b1, 32'h8000_0200, 1'b0, 0);

        // redirect while fetch outstanding for three cycles
        idle(); bus.jump_flag_i = 1'b1; bus.jump_pc_i = 32'h8000_0300; bus.ifu_busy_i = 1'b1;
        step(IDF | EXF | DRP, 1'b0, 0, 1'b0, 0);
        idle(); bus.ifu_busy_i = 1'b1;
        step(IDF | DRP, 1'b0, 0, 1'b0, 0);
        step(IDF | DRP, 1'b0, 0, 1'b0, 0);
        bus.ifu_busy_i = 1'b0;
        step(IDF | DRP | RED, 1'b1, 32'h8000_0300, 1'b0, 0);
        step(NONE, 1'b0, 0, 1'b1, 0);

        // load-use on rs2 = x5
        bus.ex_load_flag_i = 1'b1; bus.ex_wb_addr_i = 5'd5;
        bus.id_rs2_addr_i = 5'd5; bus.id_rs2_en_i = 1'b1;
        step(IFH | EXF, 1'b0, 0, 1'b1, 0);
        idle();
        step(NONE, 1'b0, 0, 1'b1, 1);
        // rd = x0 never stalls
        bus.ex_load_flag_i = 1'b1; bus.ex_wb_addr_i = 5'd0;
        bus.id_rs1_addr_i = 5'd0; bus.id_rs1_en_i = 1'b1;
        step(NONE, 1'b0, 0, 1'b1, 1);
        // matching rs1 but not read, rs2 read but different
        bus.ex_wb_addr_i = 5'd7; bus.id_rs1_addr_i = 5'd7; bus.id_rs1_en_i = 1'b0;
        bus.id_rs2_addr_i = 5'd3; bus.id_rs2_en_i = 1'b1;
        step(NONE, 1'b0, 0, 1'b0, 0);

        // multdiv busy four cycles
        idle(); bus.multdiv_hold_flag_i = 1'b1;
        step(IFH | IDH | EXH | BUB, 1'b0, 0, 1'b1, 1);
        step(IFH | IDH | EXH | BUB, 1'b0, 0, 1'b0, 0);
        step(IFH | IDH | EXH | BUB, 1'b0, 0, 1'b0, 0);
        step(IFH | IDH | EXH | BUB, 1'b0, 0, 1'b1, 4);
        // LSU wait overrides: all four holds, no bubble
        bus.lsu_busy_i = 1'b1;
        step(IFH | IDH | EXH | LSH, 1'b0, 0, 1'b1, 5);
        // LSU wait masks a redirect
        idle(); bus.lsu_busy_i = 1'b1; bus.jump_flag_i = 1'b1; bus.jump_pc_i = 32'h8000_0800;
        step(IFH | IDH | EXH | LSH, 1'b0, 0, 1'b1, 6);
        idle();
        step(NONE, 1'b0, 0, 1'b1, 7);

        // pending target overwritten by newer CLINT redirect, then LSU wait in PEND
        bus.jump_flag_i = 1'b1; bus.jump_pc_i = 32'h8000_0400; bus.ifu_busy_i = 1'b1;
        step(IDF | EXF | DRP, 1'b0, 0, 1'b0, 0);
        bus.jump_pc_i = 32'h8000_0600;
        bus.clint_jump_flag_i = 1'b1; bus.clint_jump_pc_i = 32'h8000_0500;
        step(IDF | EXF | DRP, 1'b0, 0, 1'b0, 0);
        idle(); bus.lsu_busy_i = 1'b1;
        step(IFH | IDH | EXH | LSH | DRP, 1'b0, 0, 1'b0, 0);
        idle();
        step(IDF | DRP | RED, 1'b1, 32'h8000_0500, 1'b0, 0);
        step(NONE, 1'b0, 0, 1'b0, 0);

        // reset while pending discards the parked target
        bus.jump_flag_i = 1'b1; bus.jump_pc_i = 32'h8000_0700; bus.ifu_busy_i = 1'b1;
        step(IDF | EXF | DRP, 1'b0, 0, 1'b0, 0);
        idle(); rst_n = 1'b0;
        step(NONE, 1'b1, 32'h8000_0000, 1'b0, 0);
        rst_n = 1'b1;
        step(NONE, 1'b0, 0, 1'b1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
